dram_read_arbiter: RTL and testbench

DRAM_READ_ARBITER -- requirements
Module: dram_read_arbiter

---
 rtl/dram_read_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_dram_read_arbiter.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_read_arbiter.sv
// Two-requester round-robin arbiter in front of a single DRAM read engine.
// Latches per-requester read commands, issues them one at a time, routes returned data.
module dram_read_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_kick,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_num0,
  input  logic [31:0] req_num1,
  output logic [1:0]  req_busy,
  output logic [1:0]  req_we,
  output logic [31:0] req_dout,
  output logic        kick,
  input  logic        busy,
  output logic [31:0] read_addr,
  output logic [31:0] read_num,
  input  logic [31:0] buf_dout,
  input  logic        buf_we,
  output logic        grant_id,
  output logic        timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  pend_q, pend_d;
  logic [31:0] addr0_q, addr0_d;
  logic [31:0] addr1_q, addr1_d;
  logic [31:0] num0_q, num0_d;
  logic [31:0] num1_q, num1_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        kick_q, kick_d;
  logic        terr_q, terr_d;
  logic [31:0] raddr_q, raddr_d;
  logic [31:0] rnum_q, rnum_d;
  logic [1:0]  we_q, we_d;
  logic [31:0] dout_q, dout_d;

  logic        sel;
  logic [31:0] g_addr;
  logic [31:0] g_num;
  logic        done;

  // Prefer whichever requester did not own the engine last time.
  assign sel    = pend_q[~last_q] ? ~last_q : last_q;
  assign g_addr = grant_q ? addr1_q : addr0_q;
  assign g_num  = grant_q ? num1_q : num0_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    addr0_d = addr0_q;
    addr1_d = addr1_q;
    num0_d  = num0_q;
    num1_d  = num1_q;
    grant_d = grant_q;
    last_d  = last_q;
    wcnt_d  = wcnt_q;
    kick_d  = kick_q;
    terr_d  = terr_q;
    raddr_d = raddr_q;
    rnum_d  = rnum_q;
    we_d    = 2'b00;
    dout_d  = dout_q;
    done    = 1'b0;

    if (req_kick[0] && !pend_q[0]) begin
      pend_d[0] = 1'b1;
      addr0_d   = req_addr0;
      num0_d    = req_num0;
    end
    if (req_kick[1] && !pend_q[1]) begin
      pend_d[1] = 1'b1;
      addr1_d   = req_addr1;
      num1_d    = req_num1;
    end

    unique case (state_q)
      S_IDLE: begin
        if ((|pend_q) && !busy) begin
          state_d = S_ISSUE;
          grant_d = sel;
        end
      end
      S_ISSUE: begin
        raddr_d = g_addr;
        rnum_d  = g_num;
        if (g_num == 32'd0) begin
          done = 1'b1;
        end else begin
          state_d = S_ACK;
          kick_d  = 1'b1;
          wcnt_d  = 8'd0;
        end
      end
      S_ACK: begin
        wcnt_d = wcnt_q + 8'd1;
        if (busy) begin
          state_d = S_RUN;
          kick_d  = 1'b0;
        end else if (wcnt_q == WAIT_LAST) begin
          kick_d = 1'b0;
          terr_d = 1'b1;
          done   = 1'b1;
        end
      end
      S_RUN: begin
        if (!busy) begin
          done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (done) begin
      state_d = S_IDLE;
      pend_d  = pend_d & ~(2'b01 << grant_q);
      last_d  = grant_q;
    end

    // Engine data only belongs to a requester once its kick is out.
    if (state_q == S_ACK || state_q == S_RUN) begin
      we_d[grant_q] = buf_we;
      dout_d        = buf_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= 2'b00;
      addr0_q <= 32'd0;
      addr1_q <= 32'd0;
      num0_q  <= 32'd0;
      num1_q  <= 32'd0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      wcnt_q  <= 8'd0;
      kick_q  <= 1'b0;
      terr_q  <= 1'b0;
      raddr_q <= 32'd0;
      rnum_q  <= 32'd0;
      we_q    <= 2'b00;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
      num0_q  <= num0_d;
      num1_q  <= num1_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
      kick_q  <= kick_d;
      terr_q  <= terr_d;
      raddr_q <= raddr_d;
      rnum_q  <= rnum_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
    end
  end

  assign req_busy    = pend_q;
  assign req_we      = we_q;
  assign req_dout    = dout_q;
  assign kick        = kick_q;
  assign read_addr   = raddr_q;
  assign read_num    = rnum_q;
  assign grant_id    = grant_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_dram_read_arbiter.sv
// Bench for dram_read_arbiter: behavioural DRAM engine plus a
// round-robin reference model of which requester is served and with what.
module tb_dram_read_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_kick = 2'b00;
  logic [31:0] req_addr0 = '0;
  logic [31:0] req_addr1 = '0;
  logic [31:0] req_num0 = '0;
  logic [31:0] req_num1 = '0;
  logic        busy = 1'b0;
  logic        buf_we = 1'b0;
  logic [31:0] buf_dout = '0;
  logic [1:0]  req_busy;
  logic [1:0]  req_we;
  logic [31:0] req_dout;
  logic        kick;
  logic [31:0] read_addr;
  logic [31:0] read_num;
  logic        grant_id;
  logic        timeout_err;

  dram_read_arbiter #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .req_kick(req_kick),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_num0(req_num0), .req_num1(req_num1),
    .req_busy(req_busy), .req_we(req_we), .req_dout(req_dout),
    .kick(kick), .busy(busy),
    .read_addr(read_addr), .read_num(read_num),
    .buf_dout(buf_dout), .buf_we(buf_we),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { int c; logic [31:0] d; } word_t;
  typedef struct { int c; int r; logic [31:0] d; } rword_t;

  int checks = 0;
  int errors = 0;

  word_t       sent_q[$];
  rword_t      recv_q[$];
  logic [31:0] kaddr_q[$];
  logic [31:0] knum_q[$];
  int          cyc = 0;
  int          kick_cycles = 0;
  int          busy_fall_cyc = -1;
  bit          kick_prev = 0;

  bit eng_never = 0;
  int eng_delay = 2;
  int e_st = 0;
  int e_cnt = 0;
  int e_left = 0;

  // Round-robin model: requester that owned the engine last.
  bit exp_last = 1;

  // Advance one cycle, log DUT activity, and run the engine model.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (kick === 1'b1) begin
      kick_cycles++;
      if (!kick_prev) begin
        kaddr_q.push_back(read_addr);
        knum_q.push_back(read_num);
      end
    end
    kick_prev = (kick === 1'b1);
    for (int r = 0; r < 2; r++)
      if (req_we[r] === 1'b1) recv_q.push_back('{cyc, r, req_dout});
    buf_we = 1'b0;
    case (e_st)
      0: begin
        busy = 1'b0;
        if (kick === 1'b1 && !eng_never) begin
          e_cnt  = eng_delay;
          e_left = int'(read_num);
          e_st   = 1;
        end
      end
      1: begin
        e_cnt--;
        if (e_cnt <= 0) begin
          busy = 1'b1;
          e_st = 2;
        end
      end
      2: begin
        if (e_left > 0) begin
          buf_we   = 1'b1;
          buf_dout = $urandom;
          sent_q.push_back('{cyc, buf_dout});
          e_left--;
        end else begin
          busy          = 1'b0;
          busy_fall_cyc = cyc;
          e_st          = 0;
        end
      end
      default: e_st = 0;
    endcase
  endtask

  task automatic clear_logs();
    sent_q.delete();
    recv_q.delete();
    kaddr_q.delete();
    knum_q.delete();
    kick_cycles   = 0;
    busy_fall_cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_kick = 2'b00;
    e_st = 0;
    busy = 1'b0;
    buf_we = 1'b0;
    repeat (3) cycle();
    checks++;
    if ({req_busy, req_we} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_busy_we: got %b expected 0000", {req_busy, req_we});
    end
    checks++;
    if ({kick, timeout_err, grant_id} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {kick, timeout_err, grant_id});
    end
    checks++;
    if ({read_addr, read_num, req_dout} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h expected 0", read_addr, read_num, req_dout);
    end
    rst = 1'b0;
    exp_last = 1;
    cycle();
  endtask

  task automatic test_single_read();
    int rbf;
    int bad;
    clear_logs();
    eng_delay = 2;
    req_addr0 = 32'h100;
    req_num0  = 32'h40;
    req_kick  = 2'b01;
    cycle();
    req_kick = 2'b00;
    checks++;
    if (req_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_set: got %b expected 1", req_busy[0]);
    end
    rbf = -1;
    for (int k = 0; k < 400; k++) begin
      cycle();
      if (req_busy[0] === 1'b0) begin
        rbf = cyc;
        break;
      end
    end
    checks++;
    if (rbf < 0) begin
      errors++;
      $display("FAIL single_complete: got busy stuck expected release");
    end
    checks++;
    if (kaddr_q.size() != 1 || kaddr_q[0] !== 32'h100 || knum_q[0] !== 32'h40) begin
      errors++;
      $display("FAIL single_issue: got %0d kicks expected 1 kick addr 100 num 40", kaddr_q.size());
    end
    bad = 0;
    if (recv_q.size() != 64 || sent_q.size() != 64) bad++;
    foreach (recv_q[i])
      if (i >= sent_q.size() || recv_q[i].r != 0 || recv_q[i].c != sent_q[i].c + 1 ||
          recv_q[i].d !== sent_q[i].d) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_data: got %0d words %0d bad expected 64 words 0 bad",
               recv_q.size(), bad);
    end
    checks++;
    if (!(rbf > busy_fall_cyc && busy_fall_cyc > 0)) begin
      errors++;
      $display("FAIL single_release_order: got release %0d busy fall %0d expected release later",
               rbf, busy_fall_cyc);
    end
    cycle();
    checks++;
    if (read_addr !== 32'h100 || read_num !== 32'h40) begin
      errors++;
      $display("FAIL single_hold: got %h %h expected 100 40", read_addr, read_num);
    end
    exp_last = 0;
  endtask

  task automatic test_zero_count();
    int hi;
    clear_logs();
    req_addr1 = $urandom;
    req_num1  = 32'd0;
    req_kick  = 2'b10;
    cycle();
    req_kick = 2'b00;
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      if (req_busy[1] === 1'b1) hi++;
      cycle();
    end
    checks++;
    if (hi < 2 || hi > 3) begin
      errors++;
      $display("FAIL zero_busy_len: got %0d expected 2..3", hi);
    end
    checks++;
    if (kick_cycles != 0) begin
      errors++;
      $display("FAIL zero_no_kick: got %0d kick cycles expected 0", kick_cycles);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL zero_no_err: got %b expected 0", timeout_err);
    end
    exp_last = 1;
  endtask

  task automatic test_ignore_rekick();
    logic [31:0] a;
    bit done;
    clear_logs();
    a = $urandom;
    req_addr0 = a;
    req_num0  = 32'd4;
    req_kick  = 2'b01;
    cycle();
    for (int k = 0; k < 3; k++) begin
      req_addr0 = a ^ 32'h0000_1000;
      req_num0  = 32'd9;
      req_kick  = 2'b01;
      cycle();
    end
    req_kick = 2'b00;
    done = 0;
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (req_busy === 2'b00) begin
        done = 1;
        break;
      end
    end
    repeat (4) cycle();
    checks++;
    if (!done || req_busy !== 2'b00) begin
      errors++;
      $display("FAIL rekick_idle: got busy %b expected 00", req_busy);
    end
    checks++;
    if (kaddr_q.size() != 1 || kaddr_q[0] !== a || knum_q[0] !== 32'd4) begin
      errors++;
      $display("FAIL rekick_issue: got %0d kicks expected 1 kick addr %h num 4", kaddr_q.size(), a);
    end
    exp_last = 0;
  endtask

  task automatic test_round_robin();
    for (int rnd = 0; rnd < 12; rnd++) begin
      logic [1:0]  mask;
      logic [31:0] a[2];
      int          n[2];
      int          order[$];
      logic [31:0] ea[$];
      int          en[$];
      int          ereq[$];
      int          bad;
      bit          done;
      clear_logs();
      mask = (rnd < 4) ? 2'b11 : 2'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) begin
        a[r] = $urandom;
        n[r] = (rnd < 4) ? $urandom_range(1, 5) : $urandom_range(0, 5);
      end
      eng_delay = $urandom_range(1, 3);
      req_addr0 = a[0];
      req_num0  = 32'(n[0]);
      req_addr1 = a[1];
      req_num1  = 32'(n[1]);
      req_kick  = mask;
      cycle();
      req_kick = 2'b00;
      done = 0;
      for (int k = 0; k < 300; k++) begin
        cycle();
        if (req_busy === 2'b00) begin
          done = 1;
          break;
        end
      end
      checks++;
      if (!done) begin
        errors++;
        $display("FAIL rr_complete round %0d: got busy %b expected 00", rnd, req_busy);
      end
      if (mask == 2'b11) begin
        order.push_back(exp_last ? 0 : 1);
        order.push_back(exp_last ? 1 : 0);
      end else begin
        order.push_back(mask == 2'b01 ? 0 : 1);
      end
      foreach (order[i]) begin
        if (n[order[i]] != 0) begin
          ea.push_back(a[order[i]]);
          en.push_back(n[order[i]]);
        end
        for (int w = 0; w < n[order[i]]; w++) ereq.push_back(order[i]);
      end
      exp_last = (order[order.size() - 1] == 1);
      bad = 0;
      if (kaddr_q.size() != ea.size()) bad++;
      foreach (ea[i])
        if (i >= kaddr_q.size() || kaddr_q[i] !== ea[i] || knum_q[i] !== 32'(en[i])) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rr_issue round %0d: got %0d kicks expected %0d (first req %0d)",
                 rnd, kaddr_q.size(), ea.size(), order[0]);
      end
      bad = 0;
      if (recv_q.size() != ereq.size()) bad++;
      foreach (recv_q[i])
        if (i >= sent_q.size() || i >= ereq.size() || recv_q[i].r != ereq[i] ||
            recv_q[i].c != sent_q[i].c + 1 || recv_q[i].d !== sent_q[i].d) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rr_data round %0d: got %0d words %0d bad expected %0d words",
                 rnd, recv_q.size(), bad, ereq.size());
      end
    end
  endtask

  task automatic test_timeout();
    bit done;
    clear_logs();
    eng_never = 1;
    req_addr0 = $urandom;
    req_num0  = 32'd4;
    req_kick  = 2'b01;
    cycle();
    req_kick = 2'b00;
    done = 0;
    for (int k = 0; k < 600; k++) begin
      cycle();
      if (req_busy[0] === 1'b0) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout_release: got busy stuck expected release");
    end
    checks++;
    if (kick_cycles != 255) begin
      errors++;
      $display("FAIL timeout_kick_len: got %0d expected 255", kick_cycles);
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flag: got %b expected 1", timeout_err);
    end
    exp_last = 0;
    clear_logs();
    eng_never = 0;
    req_addr1 = $urandom;
    req_num1  = 32'd3;
    req_kick  = 2'b10;
    cycle();
    req_kick = 2'b00;
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (req_busy === 2'b00) break;
    end
    checks++;
    if (timeout_err !== 1'b1 || recv_q.size() != 3) begin
      errors++;
      $display("FAIL timeout_sticky: got err %b words %0d expected err 1 words 3",
               timeout_err, recv_q.size());
    end
    exp_last = 1;
  endtask

  task automatic test_reset_mid();
    int kc;
    bit ok;
    clear_logs();
    eng_delay = 2;
    req_addr0 = 32'h300;
    req_num0  = 32'd64;
    req_kick  = 2'b01;
    cycle();
    req_kick = 2'b00;
    for (int k = 0; k < 200 && recv_q.size() < 20; k++) cycle();
    rst = 1'b1;
    cycle();
    checks++;
    if ({req_busy, req_we, kick, timeout_err, grant_id} !== 7'd0) begin
      errors++;
      $display("FAIL midrst_flags: got %b expected 0000000",
               {req_busy, req_we, kick, timeout_err, grant_id});
    end
    checks++;
    if ({read_addr, read_num, req_dout} !== 96'd0) begin
      errors++;
      $display("FAIL midrst_data: got %h %h %h expected 0", read_addr, read_num, req_dout);
    end
    rst = 1'b0;
    req_addr0 = 32'h400;
    req_num0  = 32'd3;
    req_kick  = 2'b01;
    cycle();
    req_kick = 2'b00;
    kc = kick_cycles;
    for (int k = 0; k < 200 && e_st != 0; k++) cycle();
    checks++;
    if (kick_cycles != kc || recv_q.size() != 20) begin
      errors++;
      $display("FAIL midrst_hold: got kicks %0d words %0d expected kicks %0d words 20",
               kick_cycles, recv_q.size(), kc);
    end
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (req_busy === 2'b00) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok || kaddr_q.size() != 2 || kaddr_q[1] !== 32'h400 || recv_q.size() != 23) begin
      errors++;
      $display("FAIL midrst_regrant: got kicks %0d words %0d expected 2 kicks words 23",
               kaddr_q.size(), recv_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_zero_count();
    test_ignore_rekick();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
